// File: rtl/spi_alu_pwm_ctrl.sv
// SPI-loaded 4-function ALU with flag readback over MISO and a PWM output
// whose duty cycle follows the last committed result.
module spi_alu_pwm_ctrl #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         SCLK,
   input  logic         MOSI,
   input  logic         SS,
   output logic         MISO,
   output logic [W-1:0] result,
   output logic         N,
   output logic         Z,
   output logic         C,
   output logic         V,
   output logic         result_valid,
   output logic         frame_err,
   output logic         velocidad
);

   localparam int FRAME = 2*W + 2;
   localparam int CW    = $clog2(FRAME + 2);
   localparam int RBW   = W + 4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] EXEC  = 2'd2;

   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
   localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME + 1);
   localparam logic [W-1:0]  PWM_LAST = {{(W-1){1'b1}}, 1'b0};

   logic sclk_s1, sclk_s2, sclk_d;
   logic mosi_s1, mosi_s2;
   logic ss_s1, ss_s2, ss_d;
   logic [1:0] warm;
   logic armed;
   logic sclk_rise, sclk_fall, ss_fall, ss_rise;

   logic [1:0]       state;
   logic [FRAME-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [RBW-1:0]   rb;

   logic [W-1:0] a_op, b_op, alu_r;
   logic [1:0]   sel;
   logic [W:0]   sum, diff;
   logic         alu_c, alu_v;

   logic [W-1:0] pwm_cnt, duty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_d  <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
         ss_s1   <= 1'b1;
         ss_s2   <= 1'b1;
         ss_d    <= 1'b1;
      end else begin
         sclk_s1 <= SCLK;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         mosi_s1 <= MOSI;
         mosi_s2 <= mosi_s1;
         ss_s1   <= SS;
         ss_s2   <= ss_s1;
         ss_d    <= ss_s2;
      end
   end

   // Frames are only accepted once a genuine SS-high has been seen after reset,
   // so an SS held low across reset release cannot start a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         warm  <= 2'd0;
         armed <= 1'b0;
      end else begin
         if (warm != 2'd2) warm <= warm + 2'd1;
         if (warm == 2'd2 && ss_s2) armed <= 1'b1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_d;
   assign sclk_fall = ~sclk_s2 & sclk_d;
   assign ss_fall   = ss_d & ~ss_s2 & armed;
   assign ss_rise   = ~ss_d & ss_s2;

   assign a_op = shreg[FRAME-1 -: W];
   assign b_op = shreg[FRAME-1-W -: W];
   assign sel  = shreg[1:0];
   assign sum  = {1'b0, a_op} + {1'b0, b_op};
   assign diff = {1'b0, a_op} - {1'b0, b_op};

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (sel)
         2'b00: begin
            alu_r = sum[W-1:0];
            alu_c = sum[W];
            alu_v = (a_op[W-1] == b_op[W-1]) && (sum[W-1] != a_op[W-1]);
         end
         2'b01: begin
            alu_r = diff[W-1:0];
            alu_c = ~diff[W];
            alu_v = (a_op[W-1] != b_op[W-1]) && (diff[W-1] != a_op[W-1]);
         end
         2'b10:   alu_r = a_op & b_op;
         default: alu_r = a_op | b_op;
      endcase
   end

   // A shift and a frame close in the same cycle both take effect: the last
   // bit lands in shreg before EXEC reads it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         shreg        <= '0;
         bit_cnt      <= '0;
         rb           <= '0;
         result       <= '0;
         N            <= 1'b0;
         Z            <= 1'b1;
         C            <= 1'b0;
         V            <= 1'b0;
         result_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         frame_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state   <= SHIFT;
                  shreg   <= '0;
                  bit_cnt <= '0;
                  rb      <= {result, N, Z, C, V};
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  shreg <= {shreg[FRAME-2:0], mosi_s2};
                  if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
               end
               if (sclk_fall) rb <= {rb[RBW-2:0], 1'b0};
               if (ss_rise) state <= EXEC;
            end
            EXEC: begin
               state <= IDLE;
               if (bit_cnt == CNT_FULL) begin
                  result       <= alu_r;
                  N            <= alu_r[W-1];
                  Z            <= (alu_r == '0);
                  C            <= alu_c;
                  V            <= alu_v;
                  result_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign MISO = (state == SHIFT) & rb[RBW-1];

   // Duty is latched only at the counter wrap so each period is whole.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt   <= '0;
         duty      <= '0;
         velocidad <= 1'b0;
      end else begin
         if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
            duty    <= result;
         end else begin
            pwm_cnt <= pwm_cnt + W'(1);
         end
         velocidad <= (pwm_cnt < duty);
      end
   end

endmodule

// File: tb/tb_spi_alu_pwm_ctrl.sv
// Directed testbench for spi_alu_pwm_ctrl at W=4: ALU ops, flags, MISO readback,
// frame errors, reset behaviour and PWM duty.
module tb_spi_alu_pwm_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         SCLK;
   logic         MOSI;
   logic         SS;
   logic         MISO;
   logic [W-1:0] result;
   logic         N, Z, C, V;
   logic         result_valid;
   logic         frame_err;
   logic         velocidad;

   int tests = 0;
   int failed = 0;
   int rv_count = 0;
   int fe_count = 0;

   spi_alu_pwm_ctrl #(.W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .SCLK         (SCLK),
      .MOSI         (MOSI),
      .SS           (SS),
      .MISO         (MISO),
      .result       (result),
      .N            (N),
      .Z            (Z),
      .C            (C),
      .V            (V),
      .result_valid (result_valid),
      .frame_err    (frame_err),
      .velocidad    (velocidad)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (result_valid) rv_count++;
      if (frame_err) fe_count++;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // SCLK at clk/8; MISO is captured just before each rising edge.
   task automatic send_frame(input logic [15:0] bits, input int nbits,
                             input bit close_on_edge, output logic [15:0] miso_bits);
      miso_bits = '0;
      @(negedge clk);
      SS = 1'b0;
      #80;
      for (int i = nbits - 1; i >= 0; i--) begin
         MOSI = bits[i];
         #40;
         miso_bits = {miso_bits[14:0], MISO};
         SCLK = 1'b1;
         if (close_on_edge && i == 0) SS = 1'b1;
         #40;
         SCLK = 1'b0;
      end
      MOSI = 1'b0;
      if (!close_on_edge) begin
         #80;
         SS = 1'b1;
      end
      wait_cycles(12);
   endtask

   task automatic test_reset;
      tests++; if (result !== 4'b0000) begin failed++; $display("[TB] FAIL reset_result: got %b expected 0000", result); end
      tests++; if ({N, Z, C, V} !== 4'b0100) begin failed++; $display("[TB] FAIL reset_flags: got %b expected 0100", {N, Z, C, V}); end
      tests++; if (MISO !== 1'b0) begin failed++; $display("[TB] FAIL reset_miso: got %b expected 0", MISO); end
      tests++; if (velocidad !== 1'b0) begin failed++; $display("[TB] FAIL reset_velocidad: got %b expected 0", velocidad); end
      tests++; if (result_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_result_valid: got %b expected 0", result_valid); end
      tests++; if (frame_err !== 1'b0) begin failed++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
   endtask

   task automatic test_add;
      logic [15:0] mb;
      int rv0, fe0;
      rv0 = rv_count; fe0 = fe_count;
      send_frame(16'({4'b0111, 4'b0001, 2'b00}), 10, 1'b0, mb);
      tests++; if (result !== 4'b1000) begin failed++; $display("[TB] FAIL add_result: got %b expected 1000", result); end
      tests++; if ({N, Z, C, V} !== 4'b1001) begin failed++; $display("[TB] FAIL add_flags: got %b expected 1001", {N, Z, C, V}); end
      tests++; if (rv_count - rv0 !== 1) begin failed++; $display("[TB] FAIL add_valid_pulses: got %0d expected 1", rv_count - rv0); end
      tests++; if (fe_count - fe0 !== 0) begin failed++; $display("[TB] FAIL add_err_pulses: got %0d expected 0", fe_count - fe0); end
   endtask

   task automatic test_sub;
      logic [15:0] mb;
      int rv0;
      rv0 = rv_count;
      send_frame(16'({4'b0011, 4'b0011, 2'b01}), 10, 1'b0, mb);
      tests++; if (result !== 4'b0000) begin failed++; $display("[TB] FAIL sub_result: got %b expected 0000", result); end
      tests++; if ({N, Z, C, V} !== 4'b0110) begin failed++; $display("[TB] FAIL sub_flags: got %b expected 0110", {N, Z, C, V}); end
      tests++; if (rv_count - rv0 !== 1) begin failed++; $display("[TB] FAIL sub_valid_pulses: got %0d expected 1", rv_count - rv0); end
   endtask

   // Runs right after test_sub, so the AND frame reads back 0000_0110 then zeros.
   task automatic test_logic;
      logic [15:0] mb;
      send_frame(16'({4'b1010, 4'b0110, 2'b10}), 10, 1'b0, mb);
      tests++; if (mb[9:0] !== 10'b0000011000) begin failed++; $display("[TB] FAIL readback_miso: got %b expected 0000011000", mb[9:0]); end
      tests++; if (result !== 4'b0010) begin failed++; $display("[TB] FAIL and_result: got %b expected 0010", result); end
      tests++; if ({N, Z, C, V} !== 4'b0000) begin failed++; $display("[TB] FAIL and_flags: got %b expected 0000", {N, Z, C, V}); end
      send_frame(16'({4'b1010, 4'b0110, 2'b11}), 10, 1'b0, mb);
      tests++; if (result !== 4'b1110) begin failed++; $display("[TB] FAIL or_result: got %b expected 1110", result); end
      tests++; if ({N, Z, C, V} !== 4'b1000) begin failed++; $display("[TB] FAIL or_flags: got %b expected 1000", {N, Z, C, V}); end
   endtask

   task automatic test_frame_err;
      logic [15:0] mb;
      int rv0, fe0;
      send_frame(16'({4'b0010, 4'b0011, 2'b00}), 10, 1'b0, mb);
      tests++; if (result !== 4'b0101) begin failed++; $display("[TB] FAIL err_setup_result: got %b expected 0101", result); end
      rv0 = rv_count; fe0 = fe_count;
      send_frame(16'h01AB, 9, 1'b0, mb);
      send_frame(16'h05F3, 11, 1'b0, mb);
      tests++; if (fe_count - fe0 !== 2) begin failed++; $display("[TB] FAIL err_pulses: got %0d expected 2", fe_count - fe0); end
      tests++; if (rv_count - rv0 !== 0) begin failed++; $display("[TB] FAIL err_valid_pulses: got %0d expected 0", rv_count - rv0); end
      tests++; if (result !== 4'b0101) begin failed++; $display("[TB] FAIL err_result_kept: got %b expected 0101", result); end
      tests++; if ({N, Z, C, V} !== 4'b0000) begin failed++; $display("[TB] FAIL err_flags_kept: got %b expected 0000", {N, Z, C, V}); end
   endtask

   task automatic test_edge_collision;
      logic [15:0] mb;
      int rv0;
      rv0 = rv_count;
      send_frame(16'({4'b0101, 4'b0101, 2'b00}), 10, 1'b1, mb);
      tests++; if (result !== 4'b1010) begin failed++; $display("[TB] FAIL collision_result: got %b expected 1010", result); end
      tests++; if ({N, Z, C, V} !== 4'b1001) begin failed++; $display("[TB] FAIL collision_flags: got %b expected 1001", {N, Z, C, V}); end
      tests++; if (rv_count - rv0 !== 1) begin failed++; $display("[TB] FAIL collision_valid_pulses: got %0d expected 1", rv_count - rv0); end
   endtask

   task automatic test_pwm;
      logic [15:0] mb;
      logic [15:0] frames [3];
      int expect_hi [3];
      int hi;
      frames[0] = 16'({4'b0011, 4'b0011, 2'b01}); expect_hi[0] = 0;
      frames[1] = 16'({4'b0111, 4'b0001, 2'b00}); expect_hi[1] = 24;
      frames[2] = 16'({4'b1111, 4'b0000, 2'b11}); expect_hi[2] = 45;
      for (int k = 0; k < 3; k++) begin
         send_frame(frames[k], 10, 1'b0, mb);
         wait_cycles(40);
         hi = 0;
         for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (velocidad === 1'b1) hi++;
         end
         tests++; if (hi !== expect_hi[k]) begin failed++; $display("[TB] FAIL pwm_duty_%0d: got %0d high cycles expected %0d", k, hi, expect_hi[k]); end
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [15:0] mb;
      int rv0, fe0;
      rv0 = rv_count; fe0 = fe_count;
      @(negedge clk);
      SS = 1'b0;
      #80;
      for (int i = 0; i < 5; i++) begin
         MOSI = 1'(i & 1);
         #40; SCLK = 1'b1;
         #40; SCLK = 1'b0;
      end
      rst = 1'b1;
      wait_cycles(3);
      tests++; if (result !== 4'b0000) begin failed++; $display("[TB] FAIL midrst_result: got %b expected 0000", result); end
      tests++; if ({N, Z, C, V} !== 4'b0100) begin failed++; $display("[TB] FAIL midrst_flags: got %b expected 0100", {N, Z, C, V}); end
      tests++; if (MISO !== 1'b0) begin failed++; $display("[TB] FAIL midrst_miso: got %b expected 0", MISO); end
      tests++; if (velocidad !== 1'b0) begin failed++; $display("[TB] FAIL midrst_velocidad: got %b expected 0", velocidad); end
      rst = 1'b0;
      wait_cycles(10);
      for (int i = 0; i < 10; i++) begin
         MOSI = 1'b1;
         #40; SCLK = 1'b1;
         #40; SCLK = 1'b0;
      end
      tests++; if (MISO !== 1'b0) begin failed++; $display("[TB] FAIL held_ss_miso: got %b expected 0", MISO); end
      MOSI = 1'b0;
      SS = 1'b1;
      wait_cycles(12);
      tests++; if (fe_count - fe0 !== 0) begin failed++; $display("[TB] FAIL held_ss_err_pulses: got %0d expected 0", fe_count - fe0); end
      tests++; if (rv_count - rv0 !== 0) begin failed++; $display("[TB] FAIL held_ss_valid_pulses: got %0d expected 0", rv_count - rv0); end
      send_frame(16'({4'b0010, 4'b0011, 2'b00}), 10, 1'b0, mb);
      tests++; if (result !== 4'b0101) begin failed++; $display("[TB] FAIL post_rst_result: got %b expected 0101", result); end
      tests++; if (rv_count - rv0 !== 1) begin failed++; $display("[TB] FAIL post_rst_valid_pulses: got %0d expected 1", rv_count - rv0); end
   endtask

   initial begin
      rst  = 1'b1;
      SS   = 1'b1;
      SCLK = 1'b0;
      MOSI = 1'b0;
      wait_cycles(3);
      test_reset;
      rst = 1'b0;
      wait_cycles(10);
      test_add;
      test_sub;
      test_logic;
      test_frame_err;
      test_edge_collision;
      test_pwm;
      test_reset_mid_frame;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      failed++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/spi_alu_pwm_ctrl.md
SPI_ALU_PWM_CTRL -- requirements
Module: spi_alu_pwm_ctrl

Interface
REQ-001 Parameter W, default 4: operand and result width; legal range 2..16.
REQ-002 Parameter FRAME derived = 2*W+2: bits per command frame.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 SCLK  input  1  SPI clock, mode 0; asynchronous to clk; max frequency clk/8.
REQ-006 MOSI  input  1  SPI data in, sampled on SCLK rising edge, MSB first.
REQ-007 SS  input  1  active-low slave select; a frame is one SS low period.
REQ-008 MISO  output  1  SPI data out, updated after each SCLK falling edge.
REQ-009 result  output  W  last committed ALU result.
REQ-010 N, Z, C, V  output  1 each  flags of the last committed result.
REQ-011 result_valid  output  1  one-cycle pulse when result/flags are committed.
REQ-012 frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-013 velocidad  output  1  PWM output with duty set by result.

Function
REQ-014 SCLK, MOSI and SS shall each pass through a 2-flop synchroniser; edges are detected on the synchronised values, giving 3-cycle input latency.
REQ-015 FSM states: IDLE, SHIFT, EXEC. IDLE->SHIFT on synced SS falling edge; SHIFT->EXEC on synced SS rising edge; EXEC->IDLE after one cycle.
REQ-016 In SHIFT, each synced SCLK rising edge shifts MOSI into a FRAME-bit register and increments a bit counter that saturates at FRAME+1.
REQ-017 Frame layout, MSB first: a[W-1:0], then b[W-1:0], then sel[1:0].
REQ-018 In EXEC with bit count == FRAME, the block shall commit result and flags, and pulse result_valid, on that same clk edge.
REQ-019 In EXEC with bit count != FRAME, the block shall pulse frame_err and leave result, flags and MISO data unchanged.
REQ-020 sel 00: result = a+b mod 2^W; C = carry out; V = signed overflow.
REQ-021 sel 01: result = a-b mod 2^W; C = 1 when a >= b unsigned (no borrow); V = signed overflow.
REQ-022 sel 10: result = a AND b; sel 11: result = a OR b; for both, C = 0 and V = 0.
REQ-023 For all operations, N = result[W-1] and Z = (result == 0).
REQ-024 On entering SHIFT, a (W+4)-bit readback register shall load {result, N, Z, C, V}.
REQ-025 MISO shall present the readback MSB from entry into SHIFT and advance one bit per synced SCLK falling edge.
REQ-026 After W+4 bits, MISO shall output 0. MISO shall be 0 outside SHIFT.
REQ-027 PWM: a free-running counter cycles 0..2^W-2 (period 2^W-1 cycles); velocidad = (counter < result), registered.
REQ-028 PWM boundaries: result 0 gives velocidad constantly 0; result 2^W-1 gives constantly 1.
REQ-029 A new result takes effect on the next counter wrap, so no partial period is produced.
REQ-030 An SS rising edge and an SCLK edge in the same synced cycle: the SCLK edge is processed first, then the frame closes.

Reset
REQ-031 While rst is high: FSM = IDLE; shift register, bit counter, readback, PWM counter and result = 0.
REQ-032 While rst is high: N = 0, Z = 1, C = 0, V = 0; MISO, velocidad, result_valid and frame_err = 0; synchroniser flops = SS high, SCLK low, MOSI low.
REQ-033 A frame in progress when rst asserts is discarded with no result_valid or frame_err pulse.
REQ-034 If SS is already low when rst releases, no frame starts until SS goes high and then low again.

Verification (W=4)
REQ-035 Frame a=0111, b=0001, sel=00 -> result=1000, N=1, Z=0, C=0, V=1; one result_valid pulse.
REQ-036 Frame a=0011, b=0011, sel=01 -> result=0000, Z=1, C=1, V=0; next frame's MISO first 8 bits = 0000_0110.
REQ-037 9-bit frame, then an 11-bit frame, after a committed result 0101 -> two frame_err pulses; result stays 0101; no result_valid.
REQ-038 result=0 / 8 / 15 -> velocidad high for 0 / 8 / 15 of every 15 cycles, measured over 3 periods.
REQ-039 rst asserted after 5 bits of a frame, then SS kept low -> all outputs at reset values; a clean following frame commits correctly.
REQ-040 a=1010, b=0110, sel=10 then sel=11 -> result 0010 then 1110 (N=1), C=0 and V=0 for both.
